bsg_runtime_timer: RTL and testbench

BSG_RUNTIME_TIMER -- requirements
Module: bsg_runtime_timer

---
 rtl/bsg_runtime_timer_if.sv | 12 +
 rtl/bsg_runtime_timer.sv | 99 +++++++++
 tb/tb_bsg_runtime_timer.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/bsg_runtime_timer_if.sv
// rtl/bsg_runtime_timer_if.sv - snooped request handshake bundle observed by the runtime timer
interface bsg_runtime_timer_if #(
  parameter int data_width_p = 128
);
  logic                    v;
  logic                    ready;
  logic [data_width_p-1:0] data;

  // The timer only observes traffic; whoever owns the real link drives every field.
  modport master (output v, output ready, output data);
  modport slave  (input  v, input  ready, input  data);
endinterface

// File: rtl/bsg_runtime_timer.sv
// rtl/bsg_runtime_timer.sv - tag-triggered start/stop runtime counter with delayed tag-done; define BSG_RUNTIME_TIMER_SATURATE_EN to saturate instead of wrap
module bsg_runtime_timer #(
  parameter int                     data_width_p    = 128,
  parameter int                     tag_offset_p    = 82,
  parameter int                     tag_width_p     = 12,
  parameter logic [tag_width_p-1:0] tag_value_p     = 12'hAED,
  parameter int                     counter_width_p = 64,
  parameter int                     reset_depth_p   = 3
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  bsg_runtime_timer_if.slave         pkt,
  input  logic                       tag_done_i,
  output logic                       tag_done_r_o,
  output logic                       running_o,
  output logic [counter_width_p-1:0] count_o
);

  typedef enum logic {
    idle_s = 1'b0,
    run_s  = 1'b1
  } state_e;

  localparam logic [counter_width_p-1:0] one_lp = {{(counter_width_p-1){1'b0}}, 1'b1};

  state_e                     state_r;
  state_e                     state_n;
  logic                       is_timer;
  logic                       clear;
  logic                       up;
  logic [counter_width_p-1:0] count_r;
  logic [counter_width_p-1:0] count_base;
  logic [counter_width_p-1:0] count_n;
  logic [reset_depth_p-1:0]   done_r;

  // The same tag both starts and stops the timer; the status register decides which.
  assign is_timer = pkt.v & pkt.ready
                  & (pkt.data[tag_offset_p +: tag_width_p] == tag_value_p);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r <= idle_s;
    end else begin
      state_r <= state_n;
    end
  end

  always_comb begin
    state_n = state_r;
    case (state_r)
      idle_s:  if (is_timer) state_n = run_s;
      run_s:   if (is_timer) state_n = idle_s;
      default: state_n = idle_s;
    endcase
  end

  assign running_o = (state_r == run_s);
  assign clear     = ~running_o & is_timer;
  assign up        = running_o;

  // Clear is applied before increment so a simultaneous clear/up lands on 1.
  always_comb begin
    count_base = clear ? '0 : count_r;
    count_n    = count_base;
    if (up) begin
`ifdef BSG_RUNTIME_TIMER_SATURATE_EN
      if (count_base != '1) begin
        count_n = count_base + one_lp;
      end
`else
      count_n = count_base + one_lp;
`endif
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      count_r <= '0;
    end else begin
      count_r <= count_n;
    end
  end

  assign count_o = count_r;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      done_r <= '0;
    end else begin
      done_r[0] <= tag_done_i;
      for (int i = 1; i < reset_depth_p; i++) begin
        done_r[i] <= done_r[i-1];
      end
    end
  end

  assign tag_done_r_o = done_r[reset_depth_p-1];

endmodule

// File: tb/tb_bsg_runtime_timer.sv
// tb/tb_bsg_runtime_timer.sv - scoreboard and vector-table bench for bsg_runtime_timer
module tb_bsg_runtime_timer;

  localparam logic [11:0] tag_on  = 12'hAED;
  localparam logic [11:0] tag_off = 12'hAEC;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        tag_done = 1'b0;
  logic        tag_done_r;
  logic        running;
  logic [63:0] count;
  logic        tag_done_r4;
  logic        running4;
  logic [3:0]  count4;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bsg_runtime_timer_if #(.data_width_p(128)) pkt ();

  bsg_runtime_timer dut (
    .clk_i        (clk),
    .reset_i      (reset),
    .pkt          (pkt.slave),
    .tag_done_i   (tag_done),
    .tag_done_r_o (tag_done_r),
    .running_o    (running),
    .count_o      (count)
  );

  bsg_runtime_timer #(.counter_width_p(4)) dut4 (
    .clk_i        (clk),
    .reset_i      (reset),
    .pkt          (pkt.slave),
    .tag_done_i   (tag_done),
    .tag_done_r_o (tag_done_r4),
    .running_o    (running4),
    .count_o      (count4)
  );

  typedef struct {
    int          stamp;
    string       name;
    logic        run;
    logic [63:0] cnt;
    logic        done;
  } exp_t;

  typedef struct {
    logic        v;
    logic        ready;
    logic [11:0] tag;
    logic        exp_run;
    logic [63:0] exp_cnt;
  } vec_t;

  exp_t sb[$];
  vec_t tbl[12];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].stamp <= cyc) begin
      exp_t e;
      e = sb.pop_front();
      check({e.name, ".running"}, {63'd0, running}, {63'd0, e.run});
      check({e.name, ".count"}, count, e.cnt);
      check({e.name, ".tag_done_r"}, {63'd0, tag_done_r}, {63'd0, e.done});
    end
  end

  // Drive one cycle of stimulus and queue what the outputs must show after the edge.
  task automatic step(input string nm, input logic rst, input logic v, input logic rdy,
                      input logic [11:0] tag, input logic exp_run, input logic [63:0] exp_cnt,
                      input logic exp_done);
    logic [127:0] d;
    exp_t e;
    @(negedge clk);
    d = {$urandom(), $urandom(), $urandom(), $urandom()};
    d[82 +: 12] = tag;
    reset     = rst;
    pkt.v     = v;
    pkt.ready = rdy;
    pkt.data  = d;
    tag_done  = 1'b1;
    e.stamp = cyc + 1;
    e.name  = nm;
    e.run   = exp_run;
    e.cnt   = exp_cnt;
    e.done  = exp_done;
    sb.push_back(e);
    @(posedge clk);
  endtask

  task automatic idle(input string nm, input logic exp_run, input logic [63:0] exp_cnt);
    step(nm, 1'b0, 1'b0, 1'b0, 12'h000, exp_run, exp_cnt, 1'b1);
  endtask

  task automatic pulse(input string nm, input logic exp_run, input logic [63:0] exp_cnt);
    step(nm, 1'b0, 1'b1, 1'b1, tag_on, exp_run, exp_cnt, 1'b1);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{1'b1, 1'b1, tag_off, 1'b0, 64'd0};
    tbl[1]  = '{1'b1, 1'b0, tag_on,  1'b0, 64'd0};
    tbl[2]  = '{1'b0, 1'b1, tag_on,  1'b0, 64'd0};
    tbl[3]  = '{1'b1, 1'b1, tag_on,  1'b1, 64'd0};
    tbl[4]  = '{1'b0, 1'b0, tag_on,  1'b1, 64'd1};
    tbl[5]  = '{1'b0, 1'b0, tag_off, 1'b1, 64'd2};
    tbl[6]  = '{1'b1, 1'b0, tag_on,  1'b1, 64'd3};
    tbl[7]  = '{1'b1, 1'b1, tag_off, 1'b1, 64'd4};
    tbl[8]  = '{1'b0, 1'b1, tag_on,  1'b1, 64'd5};
    tbl[9]  = '{1'b1, 1'b1, tag_on,  1'b0, 64'd6};
    tbl[10] = '{1'b0, 1'b0, tag_on,  1'b0, 64'd6};
    tbl[11] = '{1'b1, 1'b1, tag_off, 1'b0, 64'd6};

    pkt.v     = 1'b0;
    pkt.ready = 1'b0;
    pkt.data  = '0;

    // Reset must win over a matching packet and over tag_done_i.
    for (int i = 0; i < 16; i++) step("reset", 1'b1, 1'b1, 1'b1, tag_on, 1'b0, 64'd0, 1'b0);
    step("release1", 1'b0, 1'b0, 1'b0, 12'h000, 1'b0, 64'd0, 1'b0);
    step("release2", 1'b0, 1'b0, 1'b0, 12'h000, 1'b0, 64'd0, 1'b0);
    step("release3", 1'b0, 1'b0, 1'b0, 12'h000, 1'b0, 64'd0, 1'b1);

    for (int i = 0; i < 12; i++)
      step($sformatf("vec%0d", i), 1'b0, tbl[i].v, tbl[i].ready, tbl[i].tag,
           tbl[i].exp_run, tbl[i].exp_cnt, 1'b1);

    pulse("run100.start", 1'b1, 64'd0);
    for (int k = 1; k <= 99; k++) idle("run100.count", 1'b1, 64'(k));
    pulse("run100.stop", 1'b0, 64'd100);
    for (int k = 0; k < 5; k++) idle("run100.hold", 1'b0, 64'd100);

    pulse("rerun.start", 1'b1, 64'd0);
    for (int k = 1; k <= 3; k++) idle("rerun.count", 1'b1, 64'(k));
    pulse("rerun.stop", 1'b0, 64'd4);

    pulse("abort.start", 1'b1, 64'd0);
    for (int k = 1; k <= 49; k++) idle("abort.count", 1'b1, 64'(k));
    step("abort.reset", 1'b1, 1'b0, 1'b0, 12'h000, 1'b0, 64'd0, 1'b0);
    step("abort.chain1", 1'b0, 1'b0, 1'b0, 12'h000, 1'b0, 64'd0, 1'b0);
    step("abort.chain2", 1'b0, 1'b0, 1'b0, 12'h000, 1'b0, 64'd0, 1'b0);
    step("abort.chain3", 1'b0, 1'b0, 1'b0, 12'h000, 1'b0, 64'd0, 1'b1);
    pulse("abort.restart", 1'b1, 64'd0);
    idle("abort.count", 1'b1, 64'd1);
    pulse("abort.stop", 1'b0, 64'd2);

    pulse("narrow.start", 1'b1, 64'd0);
    for (int k = 1; k <= 19; k++) idle("narrow.count", 1'b1, 64'(k));
    pulse("narrow.stop", 1'b0, 64'd20);
    @(negedge clk);
    #1;
    check("narrow.running4", {63'd0, running4}, 64'd0);
`ifdef BSG_RUNTIME_TIMER_SATURATE_EN
    check("narrow.count4", {60'd0, count4}, 64'd15);
`else
    check("narrow.count4", {60'd0, count4}, 64'd4);
`endif
    check("scoreboard.drained", 64'(sb.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
